// File: rtl/sensor_pkg.sv
// sensor_pkg: shared definitions for the VGA activity sensor.
//   - state_t      : per-domain FSM state encoding (OFF, WAKE, ON)
//   - N_DOM_DEF    : default number of gated domains
//   - IDLE_W_DEF   : default idle counter width
//   - WAKE_W_DEF   : default wake-settle counter width
package sensor_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  localparam int N_DOM_DEF  = 10;
  localparam int IDLE_W_DEF = 8;
  localparam int WAKE_W_DEF = 4;

endpackage

// File: rtl/sensor_slice.sv
// sensor_slice: one gated domain's sensor FSM with its wake-settle counter
// (wcnt) and idle counter (icnt).
//
// state | meaning
// ------+--------------------------------------------------------------
// OFF   | domain idle, sensor low; any request starts a wake
// WAKE  | sensor high, waiting for isg to be seen high for W+1 cycles
// ON    | powered and settled; idle counter runs down between requests
//
// Ports:
//   clk_i          in  block clock
//   rst_i          in  synchronous reset, active-high
//   req_i          in  combined request (activity | wake | ~en | force)
//   isg_i          in  gating enable returned by the controller
//   idle_cycles_i  in  idle interval, 0 = never power down
//   wake_cycles_i  in  settle cycles after isg_i is seen high
//   sensor_o       out sensor request (decoded from state register)
//   ready_o        out domain powered and settled
//   wake_o         out domain is in WAKE (feeds busy)
module sensor_slice
  import sensor_pkg::*;
#(
  parameter int IDLE_W = IDLE_W_DEF,
  parameter int WAKE_W = WAKE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              isg_i,
  input  logic [IDLE_W-1:0] idle_cycles_i,
  input  logic [WAKE_W-1:0] wake_cycles_i,
  output logic              sensor_o,
  output logic              ready_o,
  output logic              wake_o
);

  state_t            state_q, state_d;
  logic [WAKE_W-1:0] wcnt_q, wcnt_d;
  logic [IDLE_W-1:0] icnt_q, icnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      wcnt_q  <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      icnt_q  <= icnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    icnt_d  = icnt_q;
    case (state_q)
      ST_OFF: begin
        if (req_i) begin
          state_d = ST_WAKE;
          wcnt_d  = wake_cycles_i;
        end
      end
      ST_WAKE: begin
        // Any low sample of isg restarts the settle window from scratch.
        if (!isg_i) begin
          wcnt_d = wake_cycles_i;
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WAKE_W'(1);
        end else begin
          state_d = ST_ON;
          icnt_d  = idle_cycles_i;
        end
      end
      ST_ON: begin
        // Losing isg outranks a request: the domain must re-settle.
        if (!isg_i) begin
          state_d = ST_WAKE;
          wcnt_d  = wake_cycles_i;
        end else if (req_i) begin
          icnt_d = idle_cycles_i;
        end else if (idle_cycles_i == '0) begin
          icnt_d = icnt_q;
        end else if (icnt_q != '0) begin
          icnt_d = icnt_q - IDLE_W'(1);
        end else begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Outputs decode the state register only, so no input reaches them
  // combinationally.
  assign sensor_o = (state_q == ST_WAKE) || (state_q == ST_ON);
  assign ready_o  = (state_q == ST_ON);
  assign wake_o   = (state_q == ST_WAKE);

endmodule

// File: rtl/activity_sensor_vga.sv
// activity_sensor_vga: per-domain sensor request generation for the VGA
// power-gating controller, closing the loop on the returned gating enables.
//
// Optional feature macro: SENSOR_FORCE_EN (adds force_i; a forced domain
// always requests, but still waits on isg_i settling before ready).
//
// Ports:
//   clk_i          in  block clock
//   rst_i          in  synchronous reset, active-high
//   en_i           in  gating enable; 0 treats every domain as active
//   idle_cycles_i  in  idle interval, 0 = never power down
//   wake_cycles_i  in  settle cycles after isg_i is seen high
//   act_i          in  per-domain activity strobe
//   wake_req_i     in  per-domain explicit wake request
//   force_i        in  per-domain force (SENSOR_FORCE_EN only)
//   isg_i          in  gating enables returned by the controller
//   sensor_o       out per-domain sensor request
//   ready_o        out per-domain powered-and-settled
//   busy_o         out any domain in WAKE
module activity_sensor_vga
  import sensor_pkg::*;
#(
  parameter int N_DOM  = N_DOM_DEF,
  parameter int IDLE_W = IDLE_W_DEF,
  parameter int WAKE_W = WAKE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [IDLE_W-1:0] idle_cycles_i,
  input  logic [WAKE_W-1:0] wake_cycles_i,
  input  logic [N_DOM-1:0]  act_i,
  input  logic [N_DOM-1:0]  wake_req_i,
`ifdef SENSOR_FORCE_EN
  input  logic [N_DOM-1:0]  force_i,
`endif
  input  logic [N_DOM-1:0]  isg_i,
  output logic [N_DOM-1:0]  sensor_o,
  output logic [N_DOM-1:0]  ready_o,
  output logic              busy_o
);

  logic [N_DOM-1:0] req;
  logic [N_DOM-1:0] wake;

`ifdef SENSOR_FORCE_EN
  assign req = act_i | wake_req_i | {N_DOM{~en_i}} | force_i;
`else
  assign req = act_i | wake_req_i | {N_DOM{~en_i}};
`endif

  for (genvar d = 0; d < N_DOM; d++) begin : g_dom
    sensor_slice #(
      .IDLE_W (IDLE_W),
      .WAKE_W (WAKE_W)
    ) u_slice (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_i         (req[d]),
      .isg_i         (isg_i[d]),
      .idle_cycles_i (idle_cycles_i),
      .wake_cycles_i (wake_cycles_i),
      .sensor_o      (sensor_o[d]),
      .ready_o       (ready_o[d]),
      .wake_o        (wake[d])
    );
  end

  assign busy_o = |wake;

endmodule
